wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage feeding the register file's single write port (RegWrite/RW/busW).
- Merges two result sources: single-cycle ALU results (back-pressurable) and late load returns from memory (never stalled).
- Buffers ALU results in a small in-order FIFO when a load return takes the port, and drops writes to x0.

Parameters:
- FIFO_DEPTH, 4, ALU pending-result FIFO entries; power of 2, minimum 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready
- alu_rd  in  `REGADDR (5)  ALU destination register
- alu_data  in  `WIDTH  ALU result
- mem_valid  in  1  load return this cycle; always accepted, no ready
- mem_rd  in  5  load destination register
- mem_data  in  `WIDTH  load data
- RegWrite  out  1  register file write enable (registered)
- RW  out  5  register file write address (registered)
- busW  out  `WIDTH  register file write data (registered)
- fifo_count  out  CNT_W  current FIFO occupancy
- RA  in  5  register file read address A (bypass compare)
- RB  in  5  register file read address B (bypass compare)
- byp_a_hit  out  1  pending commit matches RA
- byp_b_hit  out  1  pending commit matches RB
- byp_data  out  `WIDTH  pending commit data

Behaviour:
- Reset (rst_n low at posedge): RegWrite=0, RW=0, busW=0, FIFO pointers and count=0. alu_ready is forced to 0 while rst_n is low; all inputs are ignored.
- alu_ready = rst_n && (fifo_count < FIFO_DEPTH).
  - Same-cycle pop credit is not given, so a full FIFO stalls the ALU even when the head commits.
- x0 filter: an accepted ALU result with alu_rd==0 is consumed and discarded; it never enters the FIFO and never commits. The same applies to mem_valid with mem_rd==0.
- Commit selection each cycle, strict priority:
  1. Load return (mem_valid, mem_rd!=0).
  2. FIFO head (count>0).
  3. Direct ALU result (accepted, rd!=0, FIFO empty).
- Routing of an accepted ALU result with rd!=0:
  - Committed directly only if there is no load commit and the FIFO is empty.
  - Otherwise pushed to the FIFO tail. ALU order is always preserved.
- Push and pop may occur in the same cycle; count is unchanged.
- Latency: the selected commit appears on RegWrite/RW/busW at the next posedge, so the register file captures it one edge later. Minimum accept-to-visible-in-regfile is 2 edges.
- Idle cycle (no selection): RegWrite=0. RW and busW hold their last values.
- Upstream guarantees no two in-flight writes to the same rd. There is no WAW reordering check; the bench must not generate such traffic.
- Pointers wrap modulo FIFO_DEPTH. Count never exceeds FIFO_DEPTH and never underflows; either condition is an assertion failure.
- Reset mid-operation: FIFO contents are discarded, and any commit staged in the same cycle is lost (RegWrite=0 after the edge).

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - byp_a_hit = RegWrite && RW==RA && RA!=0.
  - byp_b_hit is the same comparison against RB.
  - byp_data = busW.
  - Lets decode read the value being written this cycle, which the register file still returns as old data.
- Undefined: byp_a_hit=0, byp_b_hit=0, byp_data=0. RA and RB are unused.

Decomposition:
- Shared defines/package (RISCV.sv): `WIDTH, `REGADDR, and wb_entry_t {rd[4:0], data[`WIDTH-1:0]}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t, parameter DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same synchronous active-low reset.
- wb_arbiter contains the priority select, x0 filter, output registers and bypass.

Test Plan:
- ALU only: alu rd=5, data=0x11 for 1 cycle -> next cycle RegWrite=1, RW=5, busW=0x11; fifo_count stays 0.
- Collision: same cycle alu rd=3/0xA and mem rd=4/0xB ->
  - next cycle: RW=4, busW=0xB, fifo_count=1;
  - following cycle: RW=3, busW=0xA, count=0.
- Back-pressure: mem_valid every cycle for 6 cycles with alu_valid held (rd 1..) ->
  - alu_ready drops to 0 after 4 accepts, count=4;
  - after mem stops, entries drain in order rd1..rd4, one per cycle.
- x0 filter: alu rd=0 data=0xFF, then mem rd=0 -> RegWrite never asserts; count stays 0.
- Reset mid-drain: count=3, drive rst_n=0 for 1 cycle -> RegWrite=0, count=0, alu_ready=0 during reset and 1 afterward; no stale commits.
- WB_BYPASS_EN defined: commit rd=7/0x55 with RA=7, RB=0 -> in the RegWrite cycle byp_a_hit=1, byp_data=0x55, byp_b_hit=0. Undefined build: both hits are 0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared definitions for the writeback stage:
//   WIDTH      - register / data path width
//   REGADDR    - register address width
//   wb_entry_t - one pending register-file write {rd, data}
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int WIDTH   = 32;
    localparam int REGADDR = 5;

    typedef struct packed {
        logic [REGADDR-1:0] rd;
        logic [WIDTH-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous in-order FIFO of wb_entry_t, used to hold ALU results while a
// load return owns the register-file write port.
// Ports:
//   clk, rst_n - rising-edge clock, synchronous active-low reset
//   push, din  - write din at the tail (caller guarantees !full or pop)
//   pop, dout  - dout is the current head; pop advances past it
//   count      - occupancy, 0..DEPTH
//   full/empty - count == DEPTH / count == 0
// Storage is not reset; only pointers and count are cleared.
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int   DEPTH = 4,
    localparam int  CNT_W = $clog2(DEPTH) + 1,
    localparam int  PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        din,
    output wb_entry_t        dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = entries[rdPtr];

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            entries[wrPtr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    overflowCheck:  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && full));
    underflowCheck: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback stage driving the register file's single write port. Merges
// single-cycle ALU results (back-pressurable) with late load returns (never
// stalled). ALU results that lose the port are queued in order in wb_fifo.
// Writes to x0 are consumed and dropped from both sources.
//
// Handshake: an ALU result transfers on a rising edge where alu_valid and
// alu_ready are both high; alu_ready does not depend on alu_valid. mem_valid
// has no ready and is always taken.
//
// Ports:
//   clk, rst_n                   - clock, synchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data - ALU result stream
//   mem_valid/mem_rd/mem_data    - load return (always accepted)
//   RegWrite/RW/busW             - registered register-file write port
//   fifo_count                   - pending ALU results
//   RA/RB                        - decode read addresses for bypass compare
//   byp_a_hit/byp_b_hit/byp_data - bypass of the write in flight this cycle
//
// Optional: define WB_BYPASS_EN to enable the bypass outputs; otherwise they
// are tied to zero and RA/RB are unused.
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int   FIFO_DEPTH = 4,
    localparam int  CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [REGADDR-1:0] alu_rd,
    input  logic [WIDTH-1:0]   alu_data,
    input  logic               mem_valid,
    input  logic [REGADDR-1:0] mem_rd,
    input  logic [WIDTH-1:0]   mem_data,
    output logic               RegWrite,
    output logic [REGADDR-1:0] RW,
    output logic [WIDTH-1:0]   busW,
    output logic [CNT_W-1:0]   fifo_count,
    input  logic [REGADDR-1:0] RA,
    input  logic [REGADDR-1:0] RB,
    output logic               byp_a_hit,
    output logic               byp_b_hit,
    output logic [WIDTH-1:0]   byp_data
);

    logic      fifoPush;
    logic      fifoPop;
    logic      fifoFull;
    logic      fifoEmpty;
    wb_entry_t fifoDin;
    wb_entry_t fifoHead;

    logic               aluAccept;
    logic               aluLive;
    logic               memCommit;
    logic               directAlu;
    logic               commitValid;
    logic [REGADDR-1:0] commitRd;
    logic [WIDTH-1:0]   commitData;

    // No same-cycle pop credit: a full FIFO stalls the ALU even if the head
    // commits this cycle.
    assign alu_ready = rst_n && !fifoFull;

    assign aluAccept = alu_valid && alu_ready;
    assign aluLive   = aluAccept && (alu_rd != '0);
    assign memCommit = mem_valid && (mem_rd != '0);

    // A load always wins; the FIFO head comes next; the ALU result may only
    // bypass the FIFO when nothing is queued ahead of it, which keeps ALU order.
    assign fifoPop   = !memCommit && !fifoEmpty;
    assign directAlu = aluLive && !memCommit && fifoEmpty;
    assign fifoPush  = aluLive && !directAlu;
    assign fifoDin   = '{rd: alu_rd, data: alu_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifoPush),
        .pop   (fifoPop),
        .din   (fifoDin),
        .dout  (fifoHead),
        .count (fifo_count),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    always_comb begin
        commitValid = 1'b0;
        commitRd    = '0;
        commitData  = '0;
        if (memCommit) begin
            commitValid = 1'b1;
            commitRd    = mem_rd;
            commitData  = mem_data;
        end else if (!fifoEmpty) begin
            commitValid = 1'b1;
            commitRd    = fifoHead.rd;
            commitData  = fifoHead.data;
        end else if (directAlu) begin
            commitValid = 1'b1;
            commitRd    = alu_rd;
            commitData  = alu_data;
        end
    end

    // RW/busW hold their last value on idle cycles; only RegWrite drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            RW       <= '0;
            busW     <= '0;
        end else begin
            RegWrite <= commitValid;
            if (commitValid) begin
                RW   <= commitRd;
                busW <= commitData;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // The register file still returns old data during the write cycle, so
    // decode takes busW directly on an address match (x0 never bypasses).
    assign byp_a_hit = RegWrite && (RW == RA) && (RA != '0);
    assign byp_b_hit = RegWrite && (RW == RB) && (RB != '0);
    assign byp_data  = busW;
`else
    logic unusedBypassInputs;
    assign unusedBypassInputs = ^{RA, RB};
    assign byp_a_hit = 1'b0;
    assign byp_b_hit = 1'b0;
    assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter (FIFO_DEPTH = 4). Inputs change and outputs
// are checked on the falling edge, half a cycle away from the sampling edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               clk;
    logic               rst_n;
    logic               alu_valid;
    logic               alu_ready;
    logic [REGADDR-1:0] alu_rd;
    logic [WIDTH-1:0]   alu_data;
    logic               mem_valid;
    logic [REGADDR-1:0] mem_rd;
    logic [WIDTH-1:0]   mem_data;
    logic               RegWrite;
    logic [REGADDR-1:0] RW;
    logic [WIDTH-1:0]   busW;
    logic [CNT_W-1:0]   fifo_count;
    logic [REGADDR-1:0] RA;
    logic [REGADDR-1:0] RB;
    logic               byp_a_hit;
    logic               byp_b_hit;
    logic [WIDTH-1:0]   byp_data;

    int nAsserts = 0;
    int nFail    = 0;

    wb_arbiter #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .RegWrite   (RegWrite),
        .RW         (RW),
        .busW       (busW),
        .fifo_count (fifo_count),
        .RA         (RA),
        .RB         (RB),
        .byp_a_hit  (byp_a_hit),
        .byp_b_hit  (byp_b_hit),
        .byp_data   (byp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkPort(input string tag, input logic we, input logic [4:0] rw,
                             input logic [31:0] bw, input logic [31:0] cnt);
        check({tag, ".RegWrite"}, 32'(RegWrite), 32'(we));
        check({tag, ".RW"}, 32'(RW), 32'(rw));
        check({tag, ".busW"}, busW, bw);
        check({tag, ".count"}, 32'(fifo_count), cnt);
    endtask

    initial begin
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
        RA        = '0;
        RB        = '0;

        // ---------------- reset ----------------
        tick();
        check("rst.alu_ready_low", 32'(alu_ready), 32'd0);
        tick();
        checkPort("rst", 1'b0, 5'd0, 32'h0, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst.alu_ready_high", 32'(alu_ready), 32'd1);

        // ---------------- ALU only ----------------
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        tick();
        alu_valid = 1'b0;
        checkPort("alu_only", 1'b1, 5'd5, 32'h11, 32'd0);
        tick();
        checkPort("alu_only.idle", 1'b0, 5'd5, 32'h11, 32'd0);

        // ---------------- collision ----------------
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        checkPort("coll.mem", 1'b1, 5'd4, 32'hB, 32'd1);
        tick();
        checkPort("coll.alu", 1'b1, 5'd3, 32'hA, 32'd0);
        tick();
        check("coll.idle.RegWrite", 32'(RegWrite), 32'd0);

        // ---------------- back-pressure ----------------
        // Loads every cycle for 6 cycles; ALU offers rd1..rd4 then rd5 stalls.
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp.ready%0d", k), 32'(alu_ready), (k < 4) ? 32'd1 : 32'd0);
            mem_valid = 1'b1;
            mem_rd    = 5'(10 + k);
            mem_data  = 32'h100 + 32'(k);
            alu_valid = 1'b1;
            alu_rd    = (k < 4) ? 5'(k + 1) : 5'd5;
            alu_data  = 32'h20 + 32'(alu_rd);
            tick();
            checkPort($sformatf("bp.mem%0d", k), 1'b1, 5'(10 + k), 32'h100 + 32'(k),
                      (k < 4) ? 32'(k + 1) : 32'd4);
        end
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            checkPort($sformatf("bp.drain%0d", j), 1'b1, 5'(j + 1), 32'h20 + 32'(j + 1),
                      32'(3 - j));
        end
        tick();
        checkPort("bp.idle", 1'b0, 5'd4, 32'h24, 32'd0);

        // ---------------- x0 filter ----------------
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        check("x0.ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        checkPort("x0.alu", 1'b0, 5'd4, 32'h24, 32'd0);
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hEE;
        tick();
        mem_valid = 1'b0;
        checkPort("x0.mem", 1'b0, 5'd4, 32'h24, 32'd0);

        // ---------------- reset mid-drain ----------------
        for (int k = 0; k < 3; k++) begin
            mem_valid = 1'b1; mem_rd = 5'(16 + k); mem_data = 32'h200 + 32'(k);
            alu_valid = 1'b1; alu_rd = 5'(6 + k);  alu_data = 32'h30 + 32'(k);
            tick();
        end
        checkPort("rst2.fill", 1'b1, 5'd18, 32'h202, 32'd3);
        mem_valid = 1'b0; alu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst2.ready_low", 32'(alu_ready), 32'd0);
        tick();
        checkPort("rst2.after", 1'b0, 5'd0, 32'h0, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst2.ready_high", 32'(alu_ready), 32'd1);
        tick();
        checkPort("rst2.nostale", 1'b0, 5'd0, 32'h0, 32'd0);
        tick();
        check("rst2.nostale2.RegWrite", 32'(RegWrite), 32'd0);

        // ---------------- bypass ----------------
        RA = 5'd7; RB = 5'd0;
        check("byp.idle.a", 32'(byp_a_hit), 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h55;
        tick();
        alu_valid = 1'b0;
        checkPort("byp.commit", 1'b1, 5'd7, 32'h55, 32'd0);
`ifdef WB_BYPASS_EN
        check("byp.a_hit", 32'(byp_a_hit), 32'd1);
        check("byp.data", byp_data, 32'h55);
`else
        check("byp.a_hit", 32'(byp_a_hit), 32'd0);
        check("byp.data", byp_data, 32'h0);
`endif
        check("byp.b_hit", 32'(byp_b_hit), 32'd0);
        RB = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        check("byp.b_hit7", 32'(byp_b_hit), 32'd1);
`else
        check("byp.b_hit7", 32'(byp_b_hit), 32'd0);
`endif
        tick();
        check("byp.after.a", 32'(byp_a_hit), 32'd0);
        check("byp.after.b", 32'(byp_b_hit), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
